// File: rtl/vector_framer.sv
// Vector framer: slices a continuous sample stream into vectors of a programmable
// length by tagging every Nth sample with tlast; optional upstream end-of-burst.
module vector_framer #(
  parameter logic [7:0]  SR_VECTOR_LEN          = 8'd132,
  parameter int unsigned MAX_LOG2_OF_VECTOR_LEN = 12,
  parameter int unsigned WIDTH                  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      short_cnt
);

  localparam int unsigned CW = MAX_LOG2_OF_VECTOR_LEN + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(1) << MAX_LOG2_OF_VECTOR_LEN;
  localparam logic [CW-1:0] RST_LEN = CW'(256);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [CW-1:0] count;
  logic [CW-1:0] l_active;
  logic [CW-1:0] l_pending;
  logic          honor_eob;
  logic [CW-1:0] cfg_len;
  logic          cfg_ok;
  logic          beat;
  logic          at_end;
  logic          eob_cut;
  beat_t         in_beat;

  beat_t      out_q, n_out;
  beat_t      skid0, skid1, n_skid0, n_skid1;
  logic [1:0] sc, n_sc;
  logic       ov, n_ov;
  logic       rdy, n_rdy;
  logic       out_free;

  assign cfg_len = set_data[CW-1:0];
  assign cfg_ok  = set_stb && (set_addr == SR_VECTOR_LEN) &&
                   (cfg_len >= CW'(2)) && (cfg_len <= MAX_LEN);

  assign beat    = i_tvalid & rdy & ~clear;
  assign at_end  = (count == l_active - CW'(1));
  assign eob_cut = honor_eob & i_tlast & ~at_end;
  assign in_beat = '{last: at_end | eob_cut, data: i_tdata};

  // Framing counter and configuration; new length only takes effect at count 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      l_active  <= RST_LEN;
      l_pending <= RST_LEN;
      honor_eob <= 1'b0;
      short_cnt <= '0;
    end else begin
      if (cfg_ok) begin
        l_pending <= cfg_len;
        honor_eob <= set_data[16];
      end
      if (clear) begin
        count    <= '0;
        l_active <= l_pending;
      end else begin
        if (count == '0) l_active <= l_pending;
        if (beat) begin
          count <= (at_end | eob_cut) ? '0 : count + CW'(1);
          if (eob_cut && (short_cnt != 16'hFFFF)) short_cnt <= short_cnt + 16'd1;
        end
      end
    end
  end

  // Output stage refills from the skid first so order is preserved
  always_comb begin
    n_out    = out_q;
    n_ov     = ov;
    n_skid0  = skid0;
    n_skid1  = skid1;
    n_sc     = sc;
    out_free = ~ov | o_tready;

    if (out_free) begin
      if (sc != 2'd0) begin
        n_out   = skid0;
        n_ov    = 1'b1;
        n_skid0 = skid1;
        n_sc    = sc - 2'd1;
      end else begin
        n_ov = 1'b0;
      end
    end

    if (beat) begin
      if (!n_ov) begin
        n_out = in_beat;
        n_ov  = 1'b1;
      end else begin
        if (n_sc == 2'd0) n_skid0 = in_beat;
        else              n_skid1 = in_beat;
        n_sc = n_sc + 2'd1;
      end
    end

    if (clear) begin
      n_ov = 1'b0;
      n_sc = 2'd0;
    end

    n_rdy = (n_sc != 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      ov    <= 1'b0;
      skid0 <= '0;
      skid1 <= '0;
      sc    <= 2'd0;
      rdy   <= 1'b0;
    end else begin
      out_q <= n_out;
      ov    <= n_ov;
      skid0 <= n_skid0;
      skid1 <= n_skid1;
      sc    <= n_sc;
      rdy   <= n_rdy;
    end
  end

  assign o_tvalid = ov;
  assign o_tdata  = out_q.data;
  assign o_tlast  = out_q.last;
  assign i_tready = rdy;

endmodule

// File: tb/tb_vector_framer.sv
// Randomized bench for vector_framer: a spec-level framing model feeds a
// scoreboard of expected {tlast,data}; handshake rules checked every cycle.
module tb_vector_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] short_cnt;

  vector_framer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Spec-level model state
  logic [32:0] exp_q[$];
  int  m_count = 0;
  int  m_lact  = 256;
  int  m_lpend = 256;
  bit  m_honor = 1'b0;
  int  m_short = 0;
  int  n_tl    = 0;
  bit  armed   = 1'b0;
  bit  want_valid = 1'b0;
  bit  prev_stall = 1'b0;
  bit  prev_clear = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  bit  rand_rdy = 1'b0;

  // Monitor: checks outputs between edges, then predicts the coming edge
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_o_tvalid", 64'(o_tvalid), 64'(0));
      check("rst_o_tlast",  64'(o_tlast),  64'(0));
      check("rst_o_tdata",  64'(o_tdata),  64'(0));
      check("rst_i_tready", 64'(i_tready), 64'(0));
      check("rst_short",    64'(short_cnt), 64'(0));
      exp_q.delete();
      m_count = 0; m_lact = 256; m_lpend = 256; m_honor = 1'b0; m_short = 0;
      armed = 1'b0; want_valid = 1'b0; prev_stall = 1'b0; prev_clear = 1'b0;
    end else begin
      if (armed) check("i_tready", 64'(i_tready), 64'(exp_q.size() < 3));
      if (want_valid) check("latency", 64'(o_tvalid), 64'(1));
      if (prev_stall && !prev_clear) begin
        check("hold_valid", 64'(o_tvalid), 64'(1));
        check("hold_data",  64'({o_tlast, o_tdata}), 64'({prev_last, prev_data}));
      end
      check("short_cnt", 64'(short_cnt), 64'(m_short));

      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("o_tdata", 64'(o_tdata), 64'(e[31:0]));
          check("o_tlast", 64'(o_tlast), 64'(e[32]));
        end
        if (o_tlast) n_tl++;
      end

      want_valid = 1'b0;
      if (m_count == 0) m_lact = m_lpend;
      if (clear) begin
        exp_q.delete();
        m_count = 0;
        m_lact  = m_lpend;
      end else if (i_tvalid && i_tready) begin
        bit full_end, last;
        full_end = (m_count == m_lact - 1);
        last     = full_end || (m_honor && i_tlast);
        if (!full_end && m_honor && i_tlast && m_short < 65535) m_short++;
        m_count  = last ? 0 : m_count + 1;
        want_valid = (exp_q.size() == 0);
        exp_q.push_back({last, i_tdata});
      end
      if (set_stb && set_addr == 8'd132 && set_data[12:0] >= 13'd2 && set_data[12:0] <= 13'd4096) begin
        m_lpend = int'(set_data[12:0]);
        m_honor = set_data[16];
      end

      prev_stall = o_tvalid && !o_tready;
      prev_clear = clear;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      armed      = 1'b1;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic set_reg(input int len, input bit honor);
    set_stb  = 1'b1;
    set_addr = 8'd132;
    set_data = (32'(honor) << 16) | 32'(len);
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic send_beat(input bit last);
    bit ok;
    ok = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = $urandom;
    i_tlast  = last;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (i_tready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int k = 0; k < n; k++) send_beat(1'b0);
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_tvalid) break;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // L=4, 10 back-to-back samples
    set_reg(4, 1'b0);
    n_tl = 0;
    send_n(10);
    drain();
    check("t1_tlast_count", 64'(n_tl), 64'(2));
    send_n(2);
    drain();

    // Range limits: 4096 accepted, 4097 and 1 ignored
    set_reg(4096, 1'b0);
    set_reg(4097, 1'b0);
    set_reg(1, 1'b0);
    n_tl = 0;
    send_n(8192);
    drain();
    check("t2_tlast_count", 64'(n_tl), 64'(2));

    // Mid-vector length change
    set_reg(8, 1'b0);
    send_n(6);
    set_reg(3, 1'b0);
    n_tl = 0;
    send_n(11);
    drain();
    check("t3_tlast_count", 64'(n_tl), 64'(4));

    // End-of-burst honoured: short vector then EOB on exactly the Lth sample
    set_reg(8, 1'b1);
    n_tl = 0;
    for (int k = 0; k < 11; k++) send_beat(k == 2 || k == 10);
    drain();
    check("t4_tlast_count", 64'(n_tl), 64'(2));
    check("t4_short_cnt", 64'(short_cnt), 64'(1));

    // Random valid/ready, L=5
    set_reg(5, 1'b0);
    rand_rdy = 1'b1;
    n_tl = 0;
    for (int k = 0; k < 10000; k++) begin
      while ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
      send_beat(1'(k % 7 == 3));
    end
    drain();
    check("t5_tlast_count", 64'(n_tl), 64'(2000));

    // Reset mid-vector, then clear mid-vector together with a beat
    send_n(3);
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send_n(7);
    clear    = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = $urandom;
    @(posedge clk); #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    @(negedge clk);
    check("t6_valid_after_clear", 64'(o_tvalid), 64'(0));
    @(posedge clk); #1;
    n_tl = 0;
    send_n(260);
    drain();
    check("t6_tlast_count", 64'(n_tl), 64'(1));
    check("t6_short_cnt", 64'(short_cnt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
